// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences setup / write-enable pulse / hold for a
// latch-based word array and samples the array read bus on reads.
//
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   Req_i, WrRd_i         request strobe, 1=write 0=read
//   Addr_i, WrData_i      row address and write data
//   Ready_o, Ack_o        idle flag, one-cycle completion pulse
//   RdData_o              last read result
//   RowSel_o, WEn_o       one-hot row select and write enable to array
//   ArrData_o, ArrData_i  array write bus / array read bus
`timescale 1ns/1ps
module mem_access_ctrl #(
  parameter int BUSWIDTH   = 8,
  parameter int ADDRWIDTH  = 4,
  parameter int WEN_CYCLES = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      Req_i,
  input  logic                      WrRd_i,
  input  logic [ADDRWIDTH-1:0]      Addr_i,
  input  logic [BUSWIDTH-1:0]       WrData_i,
  output logic                      Ready_o,
  output logic                      Ack_o,
  output logic [BUSWIDTH-1:0]       RdData_o,
  output logic [(1<<ADDRWIDTH)-1:0] RowSel_o,
  output logic                      WEn_o,
  output logic [BUSWIDTH-1:0]       ArrData_o,
  input  logic [BUSWIDTH-1:0]       ArrData_i
);

  localparam int DEPTH = 1 << ADDRWIDTH;
  localparam int CW    = (WEN_CYCLES > 1) ? $clog2(WEN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WEN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    SAMPLE,
    DONE
  } state_t;

  state_t          state;
  logic            op_wr;
  logic [CW-1:0]   cnt;

  // Every array-facing output is loaded one edge ahead of the state
  // that owns it, so the cells only ever see flop outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      op_wr     <= 1'b0;
      cnt       <= '0;
      Ready_o   <= 1'b1;
      Ack_o     <= 1'b0;
      RdData_o  <= '0;
      RowSel_o  <= '0;
      WEn_o     <= 1'b0;
      ArrData_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Req_i) begin
            op_wr    <= WrRd_i;
            RowSel_o <= DEPTH'(1) << Addr_i;
            if (WrRd_i) begin
              ArrData_o <= WrData_i;
            end
            Ready_o  <= 1'b0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (op_wr) begin
            WEn_o <= 1'b1;
            cnt   <= CNT_LOAD;
            state <= PULSE;
          end else begin
            state <= SAMPLE;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            WEn_o <= 1'b0;
            state <= HOLD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HOLD: begin
          RowSel_o <= '0;
          Ack_o    <= 1'b1;
          state    <= DONE;
        end
        SAMPLE: begin
          RdData_o <= ArrData_i;
          RowSel_o <= '0;
          Ack_o    <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          Ack_o   <= 1'b0;
          Ready_o <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
